// File: rtl/ub_pkg.sv
// Shared types and helpers for the multi-port unified buffer.
// Word address split: bank = low BW bits, row = remaining upper bits.
package ub_pkg;

    // Upper bound on read channels; sizes the round-robin pointer.
    localparam int MAX_RD_PORTS = 4;

    typedef logic [1:0] rr_ptr_t;

    function automatic int ub_bw(input int no_banks);
        return $clog2(no_banks);
    endfunction

    function automatic int ub_aw(input int addr_width, input int no_banks);
        return addr_width + $clog2(no_banks);
    endfunction

    function automatic logic [31:0] ub_bank_of(input logic [31:0] addr, input int bw);
        return addr & ((32'd1 << bw) - 32'd1);
    endfunction

    function automatic logic [31:0] ub_row_of(input logic [31:0] addr, input int bw);
        return addr >> bw;
    endfunction

endpackage

// File: rtl/ub_bank.sv
// One SRAM bank: byte-strobed write port and one registered read port.
// The top never reads and writes the same bank in one cycle.
module ub_bank #(
    parameter int SA_LENGTH  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_WIDTH-1:0]    wr_row_i,
    input  logic [8*SA_LENGTH-1:0]   wr_data_i,
    input  logic [SA_LENGTH-1:0]     wr_strb_i,
    input  logic                     rd_en_i,
    input  logic [ADDR_WIDTH-1:0]    rd_row_i,
    output logic [8*SA_LENGTH-1:0]   rd_data_o
);

    logic [8*SA_LENGTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [8*SA_LENGTH-1:0] rd_data_q;

    // Storage array: strobed byte writes and a registered read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < SA_LENGTH; i++) begin
                if (wr_strb_i[i]) mem_q[wr_row_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
        if (rd_en_i) rd_data_q <= mem_q[rd_row_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/unified_buffer_mp.sv
// Multi-port bank-interleaved unified buffer: one strobed write channel,
// NO_RD_PORTS read channels with per-bank round-robin arbitration.
// The write always wins its bank; a read to that bank is stalled.
// Optional macro UB_CONFLICT_CNT_EN adds a saturating stall counter output.
module unified_buffer_mp import ub_pkg::*; #(
    parameter int SA_LENGTH   = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int NO_BANKS    = 8,
    parameter int NO_RD_PORTS = 2,
    localparam int DW = 8*SA_LENGTH,
    localparam int BW = ub_bw(NO_BANKS),
    localparam int AW = ub_aw(ADDR_WIDTH, NO_BANKS)
) (
    input  logic                        CLK,
    input  logic                        ASYNC_RST,
    input  logic                        SYNC_RST,
    input  logic                        EN,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DW-1:0]               wr_data,
    input  logic [SA_LENGTH-1:0]        wr_strb,
    input  logic [NO_RD_PORTS-1:0]      rd_valid,
    output logic [NO_RD_PORTS-1:0]      rd_ready,
    input  logic [NO_RD_PORTS*AW-1:0]   rd_addr,
    output logic [NO_RD_PORTS-1:0]      rd_resp_valid,
    output logic [NO_RD_PORTS*DW-1:0]   rd_resp_data
`ifdef UB_CONFLICT_CNT_EN
   ,output logic [31:0]                 conflict_cnt
`endif
);

    logic                    active;
    logic                    wr_fire;
    logic [BW-1:0]           wr_bank;
    logic [ADDR_WIDTH-1:0]   wr_row;

    logic [MAX_RD_PORTS-1:0] rv4;
    logic [MAX_RD_PORTS-1:0] gnt4;
    logic [BW-1:0]           pbank [MAX_RD_PORTS];
    logic [ADDR_WIDTH-1:0]   prow  [MAX_RD_PORTS];

    rr_ptr_t                 rr_q [NO_BANKS];
    rr_ptr_t                 rr_d [NO_BANKS];
    logic [NO_BANKS-1:0]     bank_rd_en;
    logic [ADDR_WIDTH-1:0]   bank_rd_row [NO_BANKS];
    logic [DW-1:0]           bank_rdata  [NO_BANKS];

    logic [NO_RD_PORTS-1:0]  resp_valid_q;
    logic [BW-1:0]           resp_bank_q [NO_RD_PORTS];
    logic [DW-1:0]           hold_q      [NO_RD_PORTS];

    logic [2:0]              sum;
    logic [2:0]              nxt;
    rr_ptr_t                 idx;
    rr_ptr_t                 sel;
    logic                    sel_found;

    assign active   = EN & ~ASYNC_RST & ~SYNC_RST;
    assign wr_ready = active;
    assign wr_fire  = wr_valid & active;
    assign wr_bank  = BW'(ub_bank_of(32'(wr_addr), BW));
    assign wr_row   = ADDR_WIDTH'(ub_row_of(32'(wr_addr), BW));
    assign rv4      = MAX_RD_PORTS'(rd_valid);
    assign rd_ready = gnt4[NO_RD_PORTS-1:0];

    for (genvar p = 0; p < MAX_RD_PORTS; p++) begin : g_port
        if (p < NO_RD_PORTS) begin : g_on
            assign pbank[p] = BW'(ub_bank_of(32'(rd_addr[p*AW +: AW]), BW));
            assign prow[p]  = ADDR_WIDTH'(ub_row_of(32'(rd_addr[p*AW +: AW]), BW));
        end else begin : g_off
            assign pbank[p] = '0;
            assign prow[p]  = '0;
        end
    end

    // Per-bank round-robin pick among requesting ports; write owns its bank.
    always_comb begin
        gnt4       = '0;
        bank_rd_en = '0;
        sum        = '0;
        nxt        = '0;
        idx        = '0;
        sel        = '0;
        sel_found  = 1'b0;
        for (int b = 0; b < NO_BANKS; b++) begin
            rr_d[b]        = rr_q[b];
            bank_rd_row[b] = '0;
            sel_found      = 1'b0;
            sel            = '0;
            for (int k = 0; k < NO_RD_PORTS; k++) begin
                sum = {1'b0, rr_q[b]} + 3'(k);
                if (sum >= 3'(NO_RD_PORTS)) sum = sum - 3'(NO_RD_PORTS);
                idx = sum[1:0];
                if (!sel_found && rv4[idx] && (pbank[idx] == BW'(b))) begin
                    sel_found = 1'b1;
                    sel       = idx;
                end
            end
            if (sel_found && active && !(wr_fire && (wr_bank == BW'(b)))) begin
                gnt4[sel]      = 1'b1;
                bank_rd_en[b]  = 1'b1;
                bank_rd_row[b] = prow[sel];
                nxt = {1'b0, sel} + 3'd1;
                if (nxt >= 3'(NO_RD_PORTS)) nxt = '0;
                rr_d[b] = nxt[1:0];
            end
        end
    end

    // Round-robin pointers, frozen while disabled.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            for (int b = 0; b < NO_BANKS; b++) rr_q[b] <= '0;
        end else if (SYNC_RST) begin
            for (int b = 0; b < NO_BANKS; b++) rr_q[b] <= '0;
        end else if (EN) begin
            for (int b = 0; b < NO_BANKS; b++) rr_q[b] <= rr_d[b];
        end
    end

    for (genvar b = 0; b < NO_BANKS; b++) begin : g_bank
        ub_bank #(
            .SA_LENGTH (SA_LENGTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk_i    (CLK),
            .wr_en_i  (wr_fire && (wr_bank == BW'(b))),
            .wr_row_i (wr_row),
            .wr_data_i(wr_data),
            .wr_strb_i(wr_strb),
            .rd_en_i  (bank_rd_en[b]),
            .rd_row_i (bank_rd_row[b]),
            .rd_data_o(bank_rdata[b])
        );
    end

    // Response tracking: remember which bank serves each port; keep last data.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            resp_valid_q <= '0;
            for (int p = 0; p < NO_RD_PORTS; p++) begin
                resp_bank_q[p] <= '0;
                hold_q[p]      <= '0;
            end
        end else if (SYNC_RST) begin
            resp_valid_q <= '0;
            for (int p = 0; p < NO_RD_PORTS; p++) begin
                resp_bank_q[p] <= '0;
                hold_q[p]      <= '0;
            end
        end else begin
            for (int p = 0; p < NO_RD_PORTS; p++) begin
                resp_valid_q[p] <= gnt4[p];
                if (gnt4[p]) resp_bank_q[p] <= pbank[p];
                if (resp_valid_q[p]) hold_q[p] <= bank_rdata[resp_bank_q[p]];
            end
        end
    end

    // Live bank data while a response is valid, otherwise the held word.
    always_comb begin
        rd_resp_data = '0;
        for (int p = 0; p < NO_RD_PORTS; p++) begin
            rd_resp_data[p*DW +: DW] = resp_valid_q[p] ? bank_rdata[resp_bank_q[p]] : hold_q[p];
        end
    end

    assign rd_resp_valid = resp_valid_q;

`ifdef UB_CONFLICT_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        stall;

    assign stall = EN & (|(rd_valid & ~rd_ready));

    // Saturating count of cycles with at least one stalled read request.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST)     cnt_q <= '0;
        else if (SYNC_RST) cnt_q <= '0;
        else               cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_unified_buffer_mp.sv
// Directed bench for unified_buffer_mp with 4-byte words, 4 banks, 2 read ports.
module tb_unified_buffer_mp;

    localparam int SA = 4;
    localparam int NB = 4;
    localparam int AWR = 4;
    localparam int NRP = 2;
    localparam int AW = 6;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            ASYNC_RST;
    logic            SYNC_RST;
    logic            EN;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [SA-1:0]   wr_strb;
    logic [NRP-1:0]  rd_valid;
    logic [NRP-1:0]  rd_ready;
    logic [NRP*AW-1:0] rd_addr;
    logic [NRP-1:0]  rd_resp_valid;
    logic [NRP*DW-1:0] rd_resp_data;
`ifdef UB_CONFLICT_CNT_EN
    logic [31:0]     conflict_cnt;
`endif

    int checks = 0;
    int failures = 0;

    unified_buffer_mp #(
        .SA_LENGTH(SA), .ADDR_WIDTH(AWR), .NO_BANKS(NB), .NO_RD_PORTS(NRP)
    ) dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data)
`ifdef UB_CONFLICT_CNT_EN
       ,.conflict_cnt(conflict_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = '0;
    endtask

    task automatic set_write(input int a, input logic [31:0] d, input logic [3:0] s);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = d;
        wr_strb  = s;
    endtask

    task automatic set_read(input logic [1:0] v, input int a0, input int a1);
        rd_valid = v;
        rd_addr  = {AW'(a1), AW'(a0)};
    endtask

    task automatic test_reset();
        ASYNC_RST = 1'b1; SYNC_RST = 1'b0; EN = 1'b1;
        idle(); wr_addr = '0; wr_data = '0; wr_strb = '0;
        set_read(2'b01, 0, 0);
        #3;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready actual=%b required=0", wr_ready); end
        checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL reset_rd_ready actual=%b required=00", rd_ready); end
        checks++; if (rd_resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid actual=%b required=00", rd_resp_valid); end
        checks++; if (rd_resp_data !== 64'h0) begin failures++; $display("FAIL reset_resp_data actual=%h required=0", rd_resp_data); end
        @(negedge CLK);
        ASYNC_RST = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        for (int a = 0; a < 8; a++) begin
            set_write(a, 32'h11111111 * 32'(a + 1), 4'hF);
            #1;
            checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL basic_wr_ready addr=%0d actual=%b required=1", a, wr_ready); end
            tick();
        end
        idle();
        set_read(2'b01, 5, 0);
        #1;
        checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL basic_rd_ready actual=%b required=01", rd_ready); end
        tick();
        idle();
        checks++; if (rd_resp_valid !== 2'b01) begin failures++; $display("FAIL basic_resp_valid actual=%b required=01", rd_resp_valid); end
        checks++; if (rd_resp_data[31:0] !== 32'h66666666) begin failures++; $display("FAIL basic_resp_data actual=%h required=66666666", rd_resp_data[31:0]); end
        tick();
        checks++; if (rd_resp_valid !== 2'b00) begin failures++; $display("FAIL basic_valid_drop actual=%b required=00", rd_resp_valid); end
        checks++; if (rd_resp_data[31:0] !== 32'h66666666) begin failures++; $display("FAIL basic_data_hold actual=%h required=66666666", rd_resp_data[31:0]); end
    endtask

    task automatic test_strobe();
        set_write(3, 32'hAABBCCDD, 4'hF); tick();
        set_write(3, 32'h00000011, 4'b0001); tick();
        set_write(3, 32'hFFFFFFFF, 4'b0000);
        #1;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL strobe_zero_wr_ready actual=%b required=1", wr_ready); end
        tick();
        idle();
        set_read(2'b01, 3, 0);
        tick();
        idle();
        checks++; if (rd_resp_data[31:0] !== 32'hAABBCC11) begin failures++; $display("FAIL strobe_data actual=%h required=aabbcc11", rd_resp_data[31:0]); end
    endtask

    task automatic test_parallel();
        set_read(2'b11, 0, 1);
        #1;
        checks++; if (rd_ready !== 2'b11) begin failures++; $display("FAIL parallel_rd_ready actual=%b required=11", rd_ready); end
        tick();
        idle();
        checks++; if (rd_resp_valid !== 2'b11) begin failures++; $display("FAIL parallel_resp_valid actual=%b required=11", rd_resp_valid); end
        checks++; if (rd_resp_data !== 64'h22222222_11111111) begin failures++; $display("FAIL parallel_data actual=%h required=2222222211111111", rd_resp_data); end
    endtask

    task automatic test_sync_reset_conflict();
        logic [1:0] exp_rdy [3];
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01;
        SYNC_RST = 1'b1;
        set_read(2'b11, 4, 8);
        #1;
        checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL sync_rst_rd_ready actual=%b required=00", rd_ready); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL sync_rst_wr_ready actual=%b required=0", wr_ready); end
        tick();
        SYNC_RST = 1'b0;
        idle();
        checks++; if (rd_resp_valid !== 2'b00) begin failures++; $display("FAIL sync_rst_resp_valid actual=%b required=00", rd_resp_valid); end
        checks++; if (rd_resp_data !== 64'h0) begin failures++; $display("FAIL sync_rst_resp_data actual=%h required=0", rd_resp_data); end
`ifdef UB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 32'd0) begin failures++; $display("FAIL sync_rst_cnt actual=%0d required=0", conflict_cnt); end
`endif
        set_write(8, 32'h99999999, 4'hF); tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            set_read(2'b11, 4, 8);
            #1;
            checks++; if (rd_ready !== exp_rdy[c]) begin failures++; $display("FAIL rr_ready cycle=%0d actual=%b required=%b", c, rd_ready, exp_rdy[c]); end
            tick();
            checks++; if (rd_resp_valid !== exp_rdy[c]) begin failures++; $display("FAIL rr_resp_valid cycle=%0d actual=%b required=%b", c, rd_resp_valid, exp_rdy[c]); end
            if (exp_rdy[c][0]) begin
                checks++; if (rd_resp_data[31:0] !== 32'h55555555) begin failures++; $display("FAIL rr_data0 cycle=%0d actual=%h required=55555555", c, rd_resp_data[31:0]); end
            end else begin
                checks++; if (rd_resp_data[63:32] !== 32'h99999999) begin failures++; $display("FAIL rr_data1 cycle=%0d actual=%h required=99999999", c, rd_resp_data[63:32]); end
            end
        end
        idle();
        checks++; if (rd_resp_data[63:32] !== 32'h99999999) begin failures++; $display("FAIL rr_hold1 actual=%h required=99999999", rd_resp_data[63:32]); end
`ifdef UB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 32'd3) begin failures++; $display("FAIL rr_cnt actual=%0d required=3", conflict_cnt); end
`endif
    endtask

    task automatic test_en_off();
        EN = 1'b0;
        set_write(1, 32'h0, 4'hF);
        set_read(2'b01, 1, 0);
        #1;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL en_off_wr_ready actual=%b required=0", wr_ready); end
        checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL en_off_rd_ready actual=%b required=00", rd_ready); end
        tick();
        checks++; if (rd_resp_valid !== 2'b00) begin failures++; $display("FAIL en_off_resp_valid actual=%b required=00", rd_resp_valid); end
        EN = 1'b1;
        wr_valid = 1'b0;
        #1;
        checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL en_on_rd_ready actual=%b required=01", rd_ready); end
        tick();
        idle();
        checks++; if (rd_resp_data[31:0] !== 32'h22222222) begin failures++; $display("FAIL en_off_mem_frozen actual=%h required=22222222", rd_resp_data[31:0]); end
`ifdef UB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 32'd3) begin failures++; $display("FAIL en_off_cnt actual=%0d required=3", conflict_cnt); end
`endif
    endtask

    task automatic test_hazard();
        set_write(2, 32'hDEADBEEF, 4'hF);
        set_read(2'b11, 2, 6);
        #1;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL hazard_wr_ready actual=%b required=1", wr_ready); end
        checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL hazard_rd_stall actual=%b required=00", rd_ready); end
        tick();
        wr_valid = 1'b0;
        set_read(2'b01, 2, 0);
        #1;
        checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL hazard_retry_ready actual=%b required=01", rd_ready); end
        tick();
        idle();
        checks++; if (rd_resp_valid !== 2'b01) begin failures++; $display("FAIL hazard_resp_valid actual=%b required=01", rd_resp_valid); end
        checks++; if (rd_resp_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL hazard_data actual=%h required=deadbeef", rd_resp_data[31:0]); end
`ifdef UB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 32'd4) begin failures++; $display("FAIL hazard_cnt actual=%0d required=4", conflict_cnt); end
`endif
    endtask

    task automatic test_async_reset_mid_read();
        set_read(2'b01, 2, 0);
        #1;
        checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL arst_pre_ready actual=%b required=01", rd_ready); end
        @(posedge CLK);
        #1;
        ASYNC_RST = 1'b1;
        #1;
        checks++; if (rd_resp_valid !== 2'b00) begin failures++; $display("FAIL arst_resp_dropped actual=%b required=00", rd_resp_valid); end
        checks++; if (rd_resp_data[31:0] !== 32'h0) begin failures++; $display("FAIL arst_resp_data actual=%h required=0", rd_resp_data[31:0]); end
        checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL arst_rd_ready actual=%b required=00", rd_ready); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL arst_wr_ready actual=%b required=0", wr_ready); end
        @(negedge CLK);
        ASYNC_RST = 1'b0;
        #1;
        checks++; if (rd_resp_valid !== 2'b00) begin failures++; $display("FAIL arst_resp_stays0 actual=%b required=00", rd_resp_valid); end
        checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL arst_post_ready actual=%b required=01", rd_ready); end
        tick();
        idle();
        checks++; if (rd_resp_valid !== 2'b01) begin failures++; $display("FAIL arst_post_valid actual=%b required=01", rd_resp_valid); end
        checks++; if (rd_resp_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL arst_mem_kept actual=%h required=deadbeef", rd_resp_data[31:0]); end
`ifdef UB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 32'd0) begin failures++; $display("FAIL arst_cnt actual=%0d required=0", conflict_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_parallel();
        test_sync_reset_conflict();
        test_en_off();
        test_hazard();
        test_async_reset_mid_read();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
